command_encoder: RTL and testbench

Sequential instruction encoder and program loader for the 16-bit core. It accepts one instruction at a time as decoded fields over a valid/ready handshake. It packs each instruction into the 16-bit COMMAND format that DecodeUnit consumes, rejects illegal encodings, and writes the accepted words sequentially into instruction memory from address 0. It sits between the host/test loader and the instruction RAM write port.

---
 rtl/command_encoder_if.sv | 28 ++
 rtl/command_encoder.sv | 123 ++++++++++++
 tb/tb_command_encoder.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/command_encoder_if.sv
// Instruction-field handshake between the program loader and command_encoder.
// Latency: none (wires only).
// Backpressure: the slave holds in_ready low while it is not in its load state.
//
// Signals:
//   in_valid / in_ready / in_last : valid-ready handshake, last-of-program flag
//   kind, alu_op, ra, rb, cond, imm : decoded instruction fields
interface command_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_last;
  logic [2:0] kind;
  logic [3:0] alu_op;
  logic [2:0] ra;
  logic [2:0] rb;
  logic [2:0] cond;
  logic [7:0] imm;

  modport master (
    output in_valid, in_last, kind, alu_op, ra, rb, cond, imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, kind, alu_op, ra, rb, cond, imm,
    output in_ready
  );
endinterface

// File: rtl/command_encoder.sv
// Packs decoded instruction fields into 16-bit COMMAND words and loads them into instruction RAM from address 0.
// Latency: handshake at edge N -> RAM write strobe during cycle N+1; one word every 2 cycles.
// Backpressure: in_ready is high only in LOAD; an illegal word parks the block in ERR until the next start.
//
// Ports:
//   clock, reset_n         : rising-edge clock, asynchronous active-low reset
//   start                  : opens a new load session (only from IDLE/DONE/ERR)
//   bus (slave)            : instruction fields with valid/ready/last
//   mem_we/mem_addr/mem_wdata : instruction RAM write port
//   count                  : words written this session
//   busy/done/err/full     : session status
module command_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  command_encoder_if.slave  bus,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              full
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_q;
  logic [15:0] word;
  logic        legal;
  logic        take;
  logic        at_end;
  logic        restart;

  // in_ready is registered high exactly while in LOAD, so LOAD & in_valid is the handshake.
  assign take    = (state == LOAD) && bus.in_valid;
  assign at_end  = (mem_addr == {ADDR_W{1'b1}});
  assign restart = start && ((state == IDLE) || (state == DONE) || (state == ERR));

  // The word is encoded straight from the fields presented at the handshake and
  // captured into mem_wdata, so the write can go out in the very next cycle.
  always_comb begin
    word  = 16'h0000;
    legal = 1'b1;
    case (bus.kind)
      3'd0: begin
        word = {2'b11, bus.ra, bus.rb, bus.alu_op, bus.imm[3:0]};
        if ((bus.alu_op == 4'b0111) || (bus.alu_op == 4'b1110)) legal = 1'b0;
        if (bus.imm[7:4] != 4'h0) legal = 1'b0;
        // Only the shift group (10xx) may carry a non-zero shift amount.
        if ((bus.alu_op[3:2] != 2'b10) && (bus.imm[3:0] != 4'h0)) legal = 1'b0;
      end
      3'd1: word = {2'b00, bus.ra, bus.rb, bus.imm};
      3'd2: word = {2'b01, bus.ra, bus.rb, bus.imm};
      3'd3: word = {5'b10000, bus.rb, bus.imm};
      3'd4: word = {5'b10100, 3'b000, bus.imm};
      3'd5: begin
        word = {5'b10111, bus.cond, bus.imm};
        if (bus.cond > 3'd3) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (restart) state_nxt = LOAD;
      LOAD:            if (take) state_nxt = legal ? WRITE : ERR;
      WRITE:           state_nxt = (last_q || at_end) ? DONE : LOAD;
      default:         state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bus.in_ready <= 1'b0;
      mem_we       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      full         <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 16'h0000;
      count        <= '0;
      last_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      bus.in_ready <= (state_nxt == LOAD);
      mem_we       <= (state_nxt == WRITE);
      busy         <= (state_nxt == LOAD) || (state_nxt == WRITE);
      done         <= (state_nxt == DONE);
      err          <= (state_nxt == ERR);

      if (restart) begin
        mem_addr <= '0;
        count    <= '0;
        full     <= 1'b0;
      end

      // Illegal words leave mem_wdata untouched; it only changes ahead of a write.
      if (take && legal) begin
        mem_wdata <= word;
        last_q    <= bus.in_last;
      end

      if (state == WRITE) begin
        count <= count + (ADDR_W + 1)'(1);
        // The top address is sticky: flag full instead of wrapping.
        if (at_end) full <= 1'b1;
        else        mem_addr <= mem_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_command_encoder.sv
// Directed bench for command_encoder: two instances (ADDR_W=8 and ADDR_W=2), a field-level
// encoding model, write scoreboards checked every cycle, and hand-computed literal words.
module tb_command_encoder;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  always #5 clock = ~clock;

  command_encoder_if bus1 ();
  command_encoder_if bus2 ();

  logic        we1, busy1, done1, err1, full1;
  logic [7:0]  addr1;
  logic [15:0] wd1;
  logic [8:0]  cnt1;
  logic        we2, busy2, done2, err2, full2;
  logic [1:0]  addr2;
  logic [15:0] wd2;
  logic [2:0]  cnt2;

  command_encoder #(.ADDR_W(8)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .bus(bus1),
    .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1), .count(cnt1),
    .busy(busy1), .done(done1), .err(err1), .full(full1)
  );

  command_encoder #(.ADDR_W(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .bus(bus2),
    .mem_we(we2), .mem_addr(addr2), .mem_wdata(wd2), .count(cnt2),
    .busy(busy2), .done(done2), .err(err2), .full(full2)
  );

  int checks = 0;
  int fails  = 0;

  // Model state per instance: next write address, words written, full flag.
  int          m_addr [2];
  int          m_cnt  [2];
  bit          m_full [2];
  logic [23:0] q1 [$];
  logic [23:0] q2 [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Returns {legal, word} from the instruction-format table.
  function automatic logic [16:0] model_enc(input logic [2:0] k, input logic [3:0] op,
                                            input logic [2:0] a, input logic [2:0] b,
                                            input logic [2:0] c, input logic [7:0] im);
    logic [15:0] w;
    bit ok;
    ok = 1;
    w  = 16'h0;
    case (k)
      3'd0: begin
        w  = 16'hC000 | (16'(a) << 11) | (16'(b) << 8) | (16'(op) << 4) | 16'(im[3:0]);
        ok = (op != 4'd7) && (op != 4'd14) && (im[7:4] == 0) &&
             ((op >= 4'd8 && op <= 4'd11) || im[3:0] == 0);
      end
      3'd1: w = (16'(a) << 11) | (16'(b) << 8) | 16'(im);
      3'd2: w = 16'h4000 | (16'(a) << 11) | (16'(b) << 8) | 16'(im);
      3'd3: w = 16'h8000 | (16'(b) << 8) | 16'(im);
      3'd4: w = 16'hA000 | 16'(im);
      3'd5: begin
        w  = 16'hB800 | (16'(c) << 8) | 16'(im);
        ok = (c <= 3'd3);
      end
      default: ok = 0;
    endcase
    return {ok, w};
  endfunction

  function automatic logic get_rdy(input bit sel);
    return sel ? bus2.in_ready : bus1.in_ready;
  endfunction
  function automatic logic [4:0] get_flags(input bit sel);
    return sel ? {bus2.in_ready, done2, err2, busy2, full2} : {bus1.in_ready, done1, err1, busy1, full1};
  endfunction
  function automatic logic [31:0] get_cnt(input bit sel);
    return sel ? 32'(cnt2) : 32'(cnt1);
  endfunction
  function automatic logic [31:0] get_addr(input bit sel);
    return sel ? 32'(addr2) : 32'(addr1);
  endfunction

  // Flags are packed {in_ready, done, err, busy, full}.
  task automatic chk_status(input bit sel, input string tag, input bit rdy, input bit dn,
                            input bit er, input bit bz, input bit fl);
    chk({tag, ".flags"}, 32'(get_flags(sel)), 32'({rdy, dn, er, bz, fl}));
    chk({tag, ".count"}, get_cnt(sel), m_cnt[sel]);
    chk({tag, ".addr"}, get_addr(sel), m_addr[sel]);
  endtask

  task automatic drive(input bit sel, input bit v, input logic [2:0] k, input logic [3:0] op,
                       input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                       input logic [7:0] im, input bit last);
    if (sel) begin
      bus2.in_valid = v; bus2.kind = k; bus2.alu_op = op; bus2.ra = a;
      bus2.rb = b; bus2.cond = c; bus2.imm = im; bus2.in_last = last;
    end else begin
      bus1.in_valid = v; bus1.kind = k; bus1.alu_op = op; bus1.ra = a;
      bus1.rb = b; bus1.cond = c; bus1.imm = im; bus1.in_last = last;
    end
  endtask

  task automatic do_start(input bit sel, input string tag);
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clock); #1;
    if (sel) start2 = 1'b0; else start1 = 1'b0;
    m_addr[sel] = 0; m_cnt[sel] = 0; m_full[sel] = 0;
    chk_status(sel, tag, 1, 0, 0, 1, 0);
  endtask

  // Called and returns at 1 time unit after a rising edge.
  task automatic send(input bit sel, input logic [2:0] k, input logic [3:0] op,
                      input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                      input logic [7:0] im, input bit last,
                      input bit exp_ok, input logic [15:0] exp_w, input string nm);
    logic [16:0] m;
    int n;
    m = model_enc(k, op, a, b, c, im);
    chk({nm, ".model_ok"}, 32'(m[16]), 32'(exp_ok));
    if (exp_ok) chk({nm, ".model_word"}, 32'(m[15:0]), 32'(exp_w));
    n = 0;
    while (get_rdy(sel) !== 1'b1 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    if (get_rdy(sel) !== 1'b1) begin
      checks++; fails++;
      $display("FAIL %s.ready_timeout: in_ready=%b after %0d cycles, expected 1", nm, get_rdy(sel), n);
      return;
    end
    drive(sel, 1, k, op, a, b, c, im, last);
    @(posedge clock); #1;
    drive(sel, 0, k, op, a, b, c, im, 0);
    if (m[16]) begin
      if (sel) q2.push_back({8'(m_addr[1]), m[15:0]});
      else     q1.push_back({8'(m_addr[0]), m[15:0]});
      m_cnt[sel]++;
      if (m_addr[sel] == (sel ? 3 : 255)) m_full[sel] = 1;
      else m_addr[sel]++;
    end
    @(negedge clock);
    chk({nm, ".mem_we"}, 32'(sel ? we2 : we1), 32'(m[16]));
    chk({nm, ".err"}, 32'(sel ? err2 : err1), 32'(!m[16]));
    chk({nm, ".ready_drop"}, 32'(get_rdy(sel)), 0);
    @(posedge clock); #1;
  endtask

  // Scoreboards: every write strobe must match the next expected {addr, word}.
  always @(negedge clock) begin
    logic [23:0] e;
    if (reset_n && we1) begin
      if (q1.size() == 0) begin
        checks++; fails++;
        $display("FAIL dut1.unexpected_write: mem_we=1 addr=0x%0h data=0x%0h, expected no write", addr1, wd1);
      end else begin
        e = q1.pop_front();
        chk("dut1.wr_addr", 32'(addr1), 32'(e[23:16]));
        chk("dut1.wr_data", 32'(wd1), 32'(e[15:0]));
      end
    end
  end

  always @(negedge clock) begin
    logic [23:0] e;
    if (reset_n && we2) begin
      if (q2.size() == 0) begin
        checks++; fails++;
        $display("FAIL dut2.unexpected_write: mem_we=1 addr=0x%0h data=0x%0h, expected no write", addr2, wd2);
      end else begin
        e = q2.pop_front();
        chk("dut2.wr_addr", 32'(addr2), 32'(e[17:16]));
        chk("dut2.wr_data", 32'(wd2), 32'(e[15:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = 0; m_cnt[i] = 0; m_full[i] = 0;
    end

    // Reset values
    repeat (2) @(negedge clock);
    chk_status(0, "reset1", 0, 0, 0, 0, 0);
    chk("reset1.mem_we", 32'(we1), 0);
    chk("reset1.mem_wdata", 32'(wd1), 0);
    chk_status(1, "reset2", 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Program 1: ADD, LD, BCC(last)
    do_start(0, "start_p1");
    send(0, 3'd0, 4'd0, 3'd1, 3'd2, 3'd0, 8'h00, 0, 1, 16'hCA00, "p1_add");
    send(0, 3'd1, 4'd0, 3'd3, 3'd4, 3'd0, 8'h10, 0, 1, 16'h1C10, "p1_ld");
    send(0, 3'd5, 4'd0, 3'd0, 3'd0, 3'd3, 8'hF0, 1, 1, 16'hBBF0, "p1_bcc");
    chk_status(0, "p1_end", 0, 1, 0, 0, 0);
    chk("p1_end.count_lit", 32'(cnt1), 3);

    // Program 2: SLL, LI, ST, B(last)
    do_start(0, "start_p2");
    send(0, 3'd0, 4'd8, 3'd0, 3'd5, 3'd0, 8'h03, 0, 1, 16'hC583, "p2_sll");
    send(0, 3'd3, 4'd0, 3'd0, 3'd7, 3'd0, 8'h55, 0, 1, 16'h8755, "p2_li");
    send(0, 3'd2, 4'd0, 3'd2, 3'd1, 3'd0, 8'h7F, 0, 1, 16'h517F, "p2_st");
    send(0, 3'd4, 4'd0, 3'd0, 3'd0, 3'd0, 8'h08, 1, 1, 16'hA008, "p2_b");
    chk_status(0, "p2_end", 0, 1, 0, 0, 0);

    // Illegal encodings, each from a fresh session
    do_start(0, "start_ill1");
    send(0, 3'd0, 4'd7, 3'd1, 3'd1, 3'd0, 8'h00, 0, 0, 16'h0, "ill_aluop");
    chk_status(0, "ill_aluop_end", 0, 0, 1, 0, 0);
    do_start(0, "start_ill2");
    send(0, 3'd5, 4'd0, 3'd0, 3'd0, 3'd4, 8'h12, 0, 0, 16'h0, "ill_cond");
    chk_status(0, "ill_cond_end", 0, 0, 1, 0, 0);
    do_start(0, "start_ill3");
    send(0, 3'd1, 4'd0, 3'd1, 3'd1, 3'd0, 8'h22, 0, 1, 16'h0922, "ill3_ld");
    send(0, 3'd0, 4'd0, 3'd1, 3'd2, 3'd0, 8'h01, 0, 0, 16'h0, "ill_add_imm");
    chk_status(0, "ill_add_imm_end", 0, 0, 1, 0, 0);
    chk("ill_add_imm_end.count_lit", 32'(cnt1), 1);
    do_start(0, "start_ill4");
    send(0, 3'd6, 4'd0, 3'd0, 3'd0, 3'd0, 8'h00, 0, 0, 16'h0, "ill_kind6");
    chk_status(0, "ill_kind6_end", 0, 0, 1, 0, 0);
    do_start(0, "start_ill5");
    send(0, 3'd0, 4'd8, 3'd0, 3'd0, 3'd0, 8'h13, 0, 0, 16'h0, "ill_shift_hi");
    chk_status(0, "ill_shift_hi_end", 0, 0, 1, 0, 0);

    // Small memory fills up: addresses 0..3, then full and done
    do_start(1, "start_fill");
    for (int i = 0; i < 4; i++)
      send(1, 3'd3, 4'd0, 3'd0, 3'(i), 3'd0, 8'(8'h10 + i), 0, 1,
           16'(16'h8010 + 16'h0101 * i), $sformatf("fill%0d", i));
    chk_status(1, "fill_end", 0, 1, 0, 0, 1);
    chk("fill_end.count_lit", 32'(cnt2), 4);
    chk("fill_end.addr_lit", 32'(addr2), 3);
    drive(1, 1, 3'd3, 4'd0, 3'd0, 3'd0, 3'd0, 8'h99, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("fifth.ready", 32'(bus2.in_ready), 0);
    end
    drive(1, 0, 3'd3, 4'd0, 3'd0, 3'd0, 3'd0, 8'h99, 0);
    chk_status(1, "fifth_end", 0, 1, 0, 0, 1);
    do_start(1, "restart_full");
    send(1, 3'd4, 4'd0, 3'd0, 3'd0, 3'd0, 8'h42, 1, 1, 16'hA042, "refill");
    chk_status(1, "refill_end", 0, 1, 0, 0, 0);

    // start held during LOAD is ignored
    do_start(0, "start_hold_s");
    send(0, 3'd1, 4'd0, 3'd2, 3'd3, 3'd0, 8'h01, 0, 1, 16'h1301, "hold_ld");
    start1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk_status(0, "start_hold", 1, 0, 0, 1, 0);
    end
    start1 = 1'b0;
    send(0, 3'd4, 4'd0, 3'd0, 3'd0, 3'd0, 8'hFF, 1, 1, 16'hA0FF, "hold_b");
    chk_status(0, "hold_end", 0, 1, 0, 0, 0);
    chk("hold_end.count_lit", 32'(cnt1), 2);

    // start from DONE, then reset in the middle of a write
    do_start(0, "start_from_done");
    drive(0, 1, 3'd0, 4'd0, 3'd7, 3'd7, 3'd0, 8'h00, 0);
    @(posedge clock); #1;
    drive(0, 0, 3'd0, 4'd0, 3'd7, 3'd7, 3'd0, 8'h00, 0);
    chk("rst.we_before", 32'(we1), 1);
    chk("rst.wdata_before", 32'(wd1), 32'hFF00);
    #2 reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = 0; m_cnt[i] = 0; m_full[i] = 0;
    end
    #1;
    chk("rst.we_after", 32'(we1), 0);
    chk("rst.wdata_after", 32'(wd1), 0);
    chk_status(0, "rst_after", 0, 0, 0, 0, 0);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    do_start(0, "start_after_rst");
    send(0, 3'd2, 4'd0, 3'd7, 3'd0, 3'd0, 8'h80, 1, 1, 16'h7880, "post_rst_st");
    chk_status(0, "post_rst_end", 0, 1, 0, 0, 0);

    repeat (2) @(posedge clock);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
